// File: rtl/id_scoreboard.sv
// Register-hazard scoreboard for the decode stage: per-register saturating counters of
// outstanding long-latency writes, multi-port completion with same-cycle bypass, ID->EX issue gating.
module id_scoreboard #(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int NUM_CMP  = 2,
   parameter int CNT_W    = 2,
   parameter int PERF_W   = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  flush_req_i,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [NUM_SRC*5-1:0]  rs_s_i,
   input  logic [NUM_SRC-1:0]    rs_used_i,
   input  logic [4:0]            rd_s_i,
   input  logic                  rd_long_i,
   input  logic [NUM_CMP-1:0]    cmp_valid_i,
   input  logic [NUM_CMP*5-1:0]  cmp_rd_s_i,
   output logic [NUM_REGS-1:0]   busy_o,
   output logic [PERF_W-1:0]     stall_cnt_o,
   output logic                  underflow_o
);
   localparam int IDX_W = 5;
   localparam int DEC_W = $clog2(NUM_CMP + 1);
   // One extra bit so the borrow of cnt - dec shows up as the sign bit.
   localparam int DIF_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0]  r_cnt [NUM_REGS];
   logic [PERF_W-1:0] r_stall_cnt;
   logic              r_underflow;

   logic [DEC_W-1:0]  w_dec [NUM_REGS];
   logic [CNT_W-1:0]  w_eff [NUM_REGS];
   logic [31:0]       w_eff_nz;
   logic [31:0]       w_eff_sat;
   logic              w_uf_any;
   logic              w_src_haz;
   logic              w_sat_haz;
   logic              w_fire;

   always_comb begin : comb_eff
      logic [DIF_W-1:0] v_diff;
      v_diff    = '0;
      w_uf_any  = 1'b0;
      w_eff_nz  = '0;
      w_eff_sat = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         w_dec[r] = '0;
         w_eff[r] = '0;
      end
      for (int r = 1; r < NUM_REGS; r++) begin
         for (int p = 0; p < NUM_CMP; p++) begin
            if (cmp_valid_i[p] && (cmp_rd_s_i[p*IDX_W +: IDX_W] == IDX_W'(r)))
               w_dec[r] = w_dec[r] + DEC_W'(1);
         end
         v_diff = DIF_W'(r_cnt[r]) - DIF_W'(w_dec[r]);
         if (v_diff[DIF_W-1])
            w_uf_any = 1'b1;
         else
            w_eff[r] = v_diff[CNT_W-1:0];
         w_eff_nz[r]  = (w_eff[r] != '0);
         w_eff_sat[r] = (w_eff[r] == CNT_MAX);
      end
   end

   always_comb begin : comb_issue
      w_src_haz = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (rs_used_i[k] && (rs_s_i[k*IDX_W +: IDX_W] != '0) &&
             w_eff_nz[rs_s_i[k*IDX_W +: IDX_W]])
            w_src_haz = 1'b1;
      end
      w_sat_haz     = rd_long_i && (rd_s_i != '0) && w_eff_sat[rd_s_i];
      issue_ready_o = !flush_req_i && !w_src_haz && !w_sat_haz;
      w_fire        = issue_valid_i && issue_ready_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGS; r++)
            r_cnt[r] <= '0;
         r_stall_cnt <= '0;
         r_underflow <= 1'b0;
      end else begin
         r_cnt[0] <= '0;
         for (int r = 1; r < NUM_REGS; r++)
            r_cnt[r] <= w_eff[r] +
               ((w_fire && rd_long_i && (rd_s_i == IDX_W'(r))) ? CNT_W'(1) : CNT_W'(0));
         if (issue_valid_i && !issue_ready_o)
            r_stall_cnt <= r_stall_cnt + PERF_W'(1);
         if (w_uf_any)
            r_underflow <= 1'b1;
      end
   end

   always_comb begin : comb_busy
      busy_o = '0;
      for (int r = 0; r < NUM_REGS; r++)
         busy_o[r] = (r_cnt[r] != '0);
   end

   assign stall_cnt_o = r_stall_cnt;
   assign underflow_o = r_underflow;

endmodule

// File: doc/id_scoreboard.md
# id_scoreboard

Parametrised register-hazard scoreboard for the decode stage. It generalises single-cycle load-use detection to any number of long-latency producers: loads, iterative mul/div, and future units. It tracks outstanding writes per architectural register with saturating counters and retires them through multiple completion ports. It gates issue from ID to EX with a valid/ready handshake, and exposes a stall performance counter and a sticky underflow error.

## Interface
Parameters:
- NUM_REGS, 32, architectural registers tracked; register 0 is never tracked.
- NUM_SRC, 2, source operands checked per issue.
- NUM_CMP, 2, completion ports (e.g. MEM load return, mul/div unit).
- CNT_W, 2, width of per-register pending counter; max outstanding = 2^CNT_W-1.
- PERF_W, 32, stall counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- flush_req_i  in  1  blocks issue this cycle; does not touch counters.
- issue_valid_i  in  1  ID holds a valid instruction.
- issue_ready_o  out  1  instruction may advance to EX this cycle.
- rs_s_i  in  NUM_SRC*5  source register indices, operand k at [5k+4:5k].
- rs_used_i  in  NUM_SRC  operand k is actually read.
- rd_s_i  in  5  destination index.
- rd_long_i  in  1  destination produced by a long-latency unit; only these are tracked.
- cmp_valid_i  in  NUM_CMP  completion of one tracked write; fires even if that instruction was squashed.
- cmp_rd_s_i  in  NUM_CMP*5  completing destination index per port.
- busy_o  out  NUM_REGS  bit r = pending counter of r non-zero (registered state).
- stall_cnt_o  out  PERF_W  cycles with issue_valid_i=1 and issue_ready_o=0.
- underflow_o  out  1  sticky; a completion hit a register with zero pending.

## Operation
- State: cnt[r], CNT_W bits, r in 1..NUM_REGS-1; cnt[0] is constant 0.
- Per-cycle completion count: dec[r] = number of ports p with cmp_valid_i[p] and cmp_rd_s_i[p]==r, for r≠0. Completions to x0 are ignored and never set the error.
- Effective count: eff[r] = cnt[r] - dec[r], clamped at 0. Completion bypass: a write completing this cycle clears the hazard in the same cycle.
- Source hazard: there is a k with rs_used_i[k], rs_s_i[k]≠0 and eff[rs_s_i[k]]≠0.
- Saturation hazard: rd_long_i, rd_s_i≠0 and eff[rd_s_i] == 2^CNT_W-1.
- issue_ready_o = !flush_req_i && !source hazard && !saturation hazard. It is combinational and independent of issue_valid_i.
- issue_fire = issue_valid_i && issue_ready_o.
- inc[r] = 1 when issue_fire, rd_long_i, rd_s_i==r and r≠0.
- Next state: cnt[r] <= eff[r] + inc[r]. An issue and a completion on the same rd in the same cycle leave the count unchanged.
- Underflow: set underflow_o when dec[r] > cnt[r] for any r. The count clamps at 0. underflow_o clears only on reset.
- WAW is allowed: multiple outstanding writes to one rd are permitted up to saturation. Readers wait until all of them complete.
- Short-latency (ALU) writes are never tracked; the forwarding network covers them.
- stall_cnt_o increments when issue_valid_i && !issue_ready_o, including flush cycles. It wraps modulo 2^PERF_W.

## Timing
- Reset (rst_i high at a clock edge) sets all cnt to 0, busy_o to 0, stall_cnt_o to 0 and underflow_o to 0. issue_ready_o then equals !flush_req_i.
- Reset mid-operation drops all pending writes. Completions arriving after reset for pre-reset issues raise underflow_o; the bench must not drive them.
- Issue to busy_o: busy_o[rd] rises one cycle after the fire edge.
- Completion to dependent issue: 0 cycles. A consumer may fire in the same cycle cmp_valid_i retires the last pending write.
- Completion to busy_o: busy_o falls one cycle after the edge.
- Critical path: cmp_rd_s_i decode, dec popcount, eff compare, issue_ready_o. NUM_CMP≤4 must close timing at the core clock.

## Test plan
- Reset: hold rst_i 2 cycles with random inputs -> busy_o=0, stall_cnt_o=0, underflow_o=0, issue_ready_o=1 with flush_req_i=0.
- Load-use: fire rd=5 long; next cycle issue rs1=5 used -> ready=0, stall_cnt_o increments each cycle. Completion on port 1 for rd=5 in cycle 4 -> ready=1 in cycle 4 (bypass), busy_o[5]=0 in cycle 5.
- x0 and unused operands: issue rd=0 long -> busy_o stays 0. Consumer with rs2=7 busy but rs_used_i[1]=0 -> ready=1.
- WAW/saturation (CNT_W=2): three fires to rd=9 -> cnt=3. Fourth issue to rd=9 -> ready=0. Same cycle completion for 9 -> ready=1, cnt stays 3.
- Dual completion: cnt[3]=2; both ports complete rd=3 in the same cycle -> cnt[3]=0 next cycle, no underflow. A third completion to 3 -> underflow_o=1, sticky until reset.
- Flush: flush_req_i=1 with a hazard-free valid issue -> ready=0, no counter change, stall_cnt_o increments by 1.
